io_mem_gen: RTL

- Parametrised memory-mapped I/O block for the single-cycle CPU data bus. Second-generation switch/LED/seven-segment port.
- Adds a configurable LED width, switch width and digit count.
- Adds switch synchronisation and debounce, sticky switch-change status with an interrupt, per-digit blanking, readback of all writable registers, and a prescaled free-running timer.
- Sits beside data memory; the CPU decodes the I/O region and drives addr, data_in and write_enable.

---
 rtl/io_mem_gen.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/io_mem_gen.sv
// rtl/io_mem_gen.sv - memory-mapped LED/switch/seven-segment/timer I/O block
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   addr, data_in         word address and write data from the CPU data bus
//   write_enable          write strobe, sampled on the rising edge
//   data_out              registered read data (1-cycle latency)
//   io_in_sw              raw asynchronous switch inputs
//   io_out_led            LED drive, 1 = lit
//   io_out_hex            active-low segments, digit i at [7i+6:7i], bit0=a
//   irq                   registered level interrupt from masked change bits
module io_mem_gen #(
  parameter int ADDR_W   = 4,
  parameter int LED_W    = 10,
  parameter int SW_W     = 10,
  parameter int HEX_N    = 6,
  parameter int DEB_DIV  = 50000,
  parameter int TICK_DIV = 50000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [31:0]         data_in,
  input  logic                write_enable,
  output logic [31:0]         data_out,
  input  logic [SW_W-1:0]     io_in_sw,
  output logic [LED_W-1:0]    io_out_led,
  output logic [7*HEX_N-1:0]  io_out_hex,
  output logic                irq
);

  localparam int HW  = 4 * HEX_N;
  localparam int DCW = $clog2(DEB_DIV);
  localparam int TCW = $clog2(TICK_DIV + 1);
  localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEB_DIV - 1);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);

  localparam logic [ADDR_W-1:0] A_LED   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_HEX   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_BLANK = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_SW    = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_CHG   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_MASK  = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_TIMER = ADDR_W'(6);

  logic [LED_W-1:0] led;
  logic [HW-1:0]    hexval;
  logic [HEX_N-1:0] blank;
  logic [SW_W-1:0]  sync1, sw_sync, samp, deb, deb_d, swchg, irqmask;
  logic [DCW-1:0]   deb_cnt;
  logic [TCW-1:0]   tick_cnt;
  logic [31:0]      timer;
  logic [31:0]      rdata;
  logic [SW_W-1:0]  agree, chg_clr;

  // Bits whose synchronised value matches the previous sample are stable.
  assign agree   = ~(sw_sync ^ samp);
  assign chg_clr = (write_enable && addr == A_CHG) ? data_in[SW_W-1:0] : '0;

  always_comb begin
    rdata = 32'h0;
    case (addr)
      A_LED:   rdata = 32'(led);
      A_HEX:   rdata = 32'(hexval);
      A_BLANK: rdata = 32'(blank);
      A_SW:    rdata = 32'(deb);
      A_CHG:   rdata = 32'(swchg);
      A_MASK:  rdata = 32'(irqmask);
      A_TIMER: rdata = timer;
      default: rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      led      <= '0;
      hexval   <= '0;
      blank    <= '1;
      irqmask  <= '0;
      sync1    <= '0;
      sw_sync  <= '0;
      samp     <= '0;
      deb      <= '0;
      deb_d    <= '0;
      swchg    <= '0;
      deb_cnt  <= '0;
      tick_cnt <= '0;
      timer    <= 32'h0;
      irq      <= 1'b0;
      data_out <= 32'h0;
    end else begin
      if (write_enable && addr == A_LED)   led     <= data_in[LED_W-1:0];
      if (write_enable && addr == A_HEX)   hexval  <= data_in[HW-1:0];
      if (write_enable && addr == A_BLANK) blank   <= data_in[HEX_N-1:0];
      if (write_enable && addr == A_MASK)  irqmask <= data_in[SW_W-1:0];

      sync1   <= io_in_sw;
      sw_sync <= sync1;

      if (deb_cnt == DEB_LAST) begin
        deb_cnt <= '0;
        samp    <= sw_sync;
        deb     <= (sw_sync & agree) | (deb & ~agree);
      end else begin
        deb_cnt <= deb_cnt + DCW'(1);
      end

      // Change detection lags deb by one cycle; OR-ing after the clear makes
      // a coincident set win over write-1-to-clear.
      deb_d <= deb;
      swchg <= (swchg & ~chg_clr) | (deb ^ deb_d);
      irq   <= |(swchg & irqmask);

      // A timer write restarts the prescaler and overrides any tick.
      if (write_enable && addr == A_TIMER) begin
        timer    <= data_in;
        tick_cnt <= '0;
      end else if (tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
        timer    <= timer + 32'd1;
      end else begin
        tick_cnt <= tick_cnt + TCW'(1);
      end

      data_out <= rdata;
    end
  end

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < HEX_N; gi++) begin : g_digit
      assign io_out_hex[7*gi +: 7] = blank[gi] ? 7'h7F : hex_seg(hexval[4*gi +: 4]);
    end
  endgenerate

  assign io_out_led = led;

endmodule
